// File: rtl/tick_period_meter.sv
// Tick period meter: recovers the enabled-cycle period of a single-cycle tick
// stream and tracks min/max period, capture count and counter saturation.
module tick_period_meter #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 tick_in,
  output logic [WIDTH-1:0]     period,
  output logic                 valid,
  output logic [WIDTH-1:0]     period_min,
  output logic [WIDTH-1:0]     period_max,
  output logic [CNT_WIDTH-1:0] meas_count,
  output logic                 overflow
);

  // state | meaning
  // IDLE  | waiting for the first tick to open the measurement window
  // ARMED | counting enabled cycles since the last tick
  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0]     CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] MEAS_MAX = '1;

  state_t               state, state_next;
  logic [WIDTH-1:0]     counter, counter_next;
  logic [WIDTH-1:0]     period_next, min_next, max_next;
  logic [CNT_WIDTH-1:0] count_next;
  logic                 valid_next, overflow_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      counter    <= '0;
      period     <= '0;
      valid      <= 1'b0;
      period_min <= CNT_MAX;
      period_max <= '0;
      meas_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_next;
      counter    <= counter_next;
      period     <= period_next;
      valid      <= valid_next;
      period_min <= min_next;
      period_max <= max_next;
      meas_count <= count_next;
      overflow   <= overflow_next;
    end
  end

  always_comb begin
    state_next    = state;
    counter_next  = counter;
    period_next   = period;
    valid_next    = 1'b0;
    min_next      = period_min;
    max_next      = period_max;
    count_next    = meas_count;
    overflow_next = overflow;

    if (clear) begin
      state_next    = IDLE;
      counter_next  = '0;
      period_next   = '0;
      min_next      = CNT_MAX;
      max_next      = '0;
      count_next    = '0;
      overflow_next = 1'b0;
    end else if (enable) begin
      unique case (state)
        IDLE: begin
          // The first tick only opens the window; there is nothing to capture yet.
          if (tick_in) begin
            state_next   = ARMED;
            counter_next = WIDTH'(1);
          end
        end
        ARMED: begin
          if (tick_in) begin
            period_next  = counter;
            valid_next   = 1'b1;
            counter_next = WIDTH'(1);
            if (counter < period_min) min_next = counter;
            if (counter > period_max) max_next = counter;
            if (meas_count != MEAS_MAX) count_next = meas_count + CNT_WIDTH'(1);
            if (counter == CNT_MAX) overflow_next = 1'b1;
          end else if (counter != CNT_MAX) begin
            counter_next = counter + WIDTH'(1);
          end else begin
            overflow_next = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter: a table of stimulus rows with
// hand-computed expectations, plus a hand-written clear/async-reset sequence.
module tb_tick_period_meter;

  logic        clk = 1'b0;
  logic        reset, enable, clear, tick_in;
  logic [31:0] period, period_min, period_max;
  logic        valid, overflow;
  logic [15:0] meas_count;
  logic [3:0]  p4, mn4, mx4;
  logic [1:0]  c4;
  logic        v4, o4;

  int total = 0;
  int passed = 0;

  localparam logic [31:0] FF = 32'hFFFF_FFFF;

  always #5 clk = ~clk;

  tick_period_meter #(.WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .tick_in(tick_in),
    .period(period), .valid(valid), .period_min(period_min), .period_max(period_max),
    .meas_count(meas_count), .overflow(overflow)
  );

  tick_period_meter #(.WIDTH(4), .CNT_WIDTH(2)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .tick_in(tick_in),
    .period(p4), .valid(v4), .period_min(mn4), .period_max(mx4),
    .meas_count(c4), .overflow(o4)
  );

  typedef struct {
    bit          d4;
    logic        en, clr, tick;
    int          n;
    logic        v;
    logic [31:0] p, mn, mx;
    logic [15:0] c;
    logic        o;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit d4, input logic en, input logic clr, input logic tick,
                     input int n, input logic v, input logic [31:0] p,
                     input logic [31:0] mn, input logic [31:0] mx,
                     input logic [15:0] c, input logic o);
    vec_t r;
    r.d4 = d4; r.en = en; r.clr = clr; r.tick = tick; r.n = n;
    r.v = v; r.p = p; r.mn = mn; r.mx = mx; r.c = c; r.o = o;
    vecs.push_back(r);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  task automatic expect_out(input string tag, input bit d4, input logic v,
                            input logic [31:0] p, input logic [31:0] mn,
                            input logic [31:0] mx, input logic [15:0] c, input logic o);
    if (d4) begin
      check({tag, " valid"},    32'(v4),  32'(v));
      check({tag, " period"},   32'(p4),  p);
      check({tag, " min"},      32'(mn4), mn);
      check({tag, " max"},      32'(mx4), mx);
      check({tag, " count"},    32'(c4),  32'(c));
      check({tag, " overflow"}, 32'(o4),  32'(o));
    end else begin
      check({tag, " valid"},    32'(valid),      32'(v));
      check({tag, " period"},   period,          p);
      check({tag, " min"},      period_min,      mn);
      check({tag, " max"},      period_max,      mx);
      check({tag, " count"},    32'(meas_count), 32'(c));
      check({tag, " overflow"}, 32'(overflow),   32'(o));
    end
  endtask

  task automatic step(input logic en, input logic clr, input logic tick, input int n);
    enable = en; clear = clr; tick_in = tick;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0; tick_in = 1'b0;
    #12;
    expect_out("reset", 0, 0, 0, FF, 0, 0, 0);
    expect_out("reset w4", 1, 0, 0, 32'd15, 0, 0, 0);
    reset = 1'b0;

    // Period 5: ticks at enabled edges 10, 15, 20, 25
    add(0,1,0,0,9, 0,0,FF,0,0,0);
    add(0,1,0,1,1, 0,0,FF,0,0,0);
    add(0,1,0,0,4, 0,0,FF,0,0,0);
    add(0,1,0,1,1, 1,5,5,5,1,0);
    add(0,1,0,0,4, 0,5,5,5,1,0);
    add(0,1,0,1,1, 1,5,5,5,2,0);
    add(0,1,0,0,4, 0,5,5,5,2,0);
    add(0,1,0,1,1, 1,5,5,5,3,0);
    add(0,1,1,1,1, 0,0,FF,0,0,0);
    // Continuous tick_in, then enable low forces valid to 0
    add(0,1,0,1,1, 0,0,FF,0,0,0);
    for (int k = 1; k <= 5; k++) add(0,1,0,1,1, 1,1,1,1,16'(k),0);
    add(0,0,0,1,1, 0,1,1,1,5,0);
    add(0,0,1,0,1, 0,0,FF,0,0,0);
    // Gaps 3, 7, 4
    add(0,1,0,1,1, 0,0,FF,0,0,0);
    add(0,1,0,0,2, 0,0,FF,0,0,0);
    add(0,1,0,1,1, 1,3,3,3,1,0);
    add(0,1,0,0,6, 0,3,3,3,1,0);
    add(0,1,0,1,1, 1,7,3,7,2,0);
    add(0,1,0,0,3, 0,7,3,7,2,0);
    add(0,1,0,1,1, 1,4,3,7,3,0);
    add(0,1,1,0,1, 0,0,FF,0,0,0);
    // Period 4 with an enable gap and a tick ignored during the gap
    add(0,1,0,1,1, 0,0,FF,0,0,0);
    add(0,1,0,0,1, 0,0,FF,0,0,0);
    add(0,0,0,0,2, 0,0,FF,0,0,0);
    add(0,0,0,1,1, 0,0,FF,0,0,0);
    add(0,1,0,0,2, 0,0,FF,0,0,0);
    add(0,1,0,1,1, 1,4,4,4,1,0);
    add(0,0,0,0,1, 0,4,4,4,1,0);
    add(0,1,1,0,1, 0,0,FF,0,0,0);
    // 4-bit counter saturation, 2-bit meas_count saturation
    add(1,1,0,1,1,  0,0,15,0,0,0);
    add(1,1,0,0,13, 0,0,15,0,0,0);
    add(1,1,0,0,1,  0,0,15,0,0,0);
    add(1,1,0,0,1,  0,0,15,0,0,1);
    add(1,1,0,0,4,  0,0,15,0,0,1);
    add(1,1,0,1,1,  1,15,15,15,1,1);
    add(1,1,0,0,2,  0,15,15,15,1,1);
    add(1,1,0,1,1,  1,3,3,15,2,1);
    add(1,1,0,0,2,  0,3,3,15,2,1);
    add(1,1,0,1,1,  1,3,3,15,3,1);
    add(1,1,0,0,2,  0,3,3,15,3,1);
    add(1,1,0,1,1,  1,3,3,15,3,1);

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].clr, vecs[i].tick, vecs[i].n);
      expect_out($sformatf("row%0d", i), vecs[i].d4, vecs[i].v, vecs[i].p,
                 vecs[i].mn, vecs[i].mx, vecs[i].c, vecs[i].o);
    end

    // Clear coinciding with a tick after two captures, then async reset mid-period
    step(1,1,0,1);
    step(1,0,1,1);
    step(1,0,0,1);
    step(1,0,1,1); expect_out("s6 cap1", 0, 1,2,2,2,1,0);
    step(1,0,0,1);
    step(1,0,1,1); expect_out("s6 cap2", 0, 1,2,2,2,2,0);
    step(1,1,1,1); expect_out("s6 clear", 0, 0,0,FF,0,0,0);
    step(1,0,1,1); expect_out("s6 rearm", 0, 0,0,FF,0,0,0);
    step(1,0,0,1);
    step(1,0,1,1); expect_out("s6 cap3", 0, 1,2,2,2,1,0);
    step(1,0,0,2); expect_out("s6 mid", 0, 0,2,2,2,1,0);
    #1 reset = 1'b1;
    #1 expect_out("s6 async", 0, 0,0,FF,0,0,0);
    #1 reset = 1'b0;
    step(1,0,1,1); expect_out("s6 post-reset tick", 0, 0,0,FF,0,0,0);
    step(1,0,0,2);
    step(1,0,1,1); expect_out("s6 post-reset cap", 0, 1,3,3,3,1,0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tick_period_meter.md
Name: tick_period_meter

Overview:
- Receiving end of the periodic tick interface: consumes a single-cycle tick stream and recovers the period as a cycle count.
- A tick stream produced with period M (tick every M enabled cycles) reads back as period = M.
- Also tracks min/max period, counts measurements and flags overflow. Used to check and calibrate timer outputs in lab designs.

Parameters:
- WIDTH, 32, width of the cycle counter and of the period/min/max outputs.
- CNT_WIDTH, 16, width of the measurement counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  count-enable; when low, counter and state hold and tick_in is ignored
- clear  input  1  synchronous clear, same effect as reset
- tick_in  input  1  tick pulse, sampled at the rising edge of clk
- period  output  WIDTH  last captured period in cycles
- valid  output  1  one-cycle pulse: period updated
- period_min  output  WIDTH  smallest captured period since reset/clear
- period_max  output  WIDTH  largest captured period since reset/clear
- meas_count  output  CNT_WIDTH  captures since reset/clear, saturating
- overflow  output  1  sticky: the counter saturated at least once

Behaviour:
- All outputs and state are registered.
- Reset values (async, on reset=1):
  - state=IDLE, counter=0, period=0, valid=0
  - period_min = all-ones, period_max=0, meas_count=0, overflow=0
- Priority per edge: reset > clear > enable=0 (hold; valid forced 0) > normal operation.
- clear=1 at an edge: every register takes its reset value, whatever tick_in or enable is.
- IDLE state:
  - On an edge with enable=1 and tick_in=1: go to ARMED, counter<=1, no capture (first tick only opens the window).
  - Otherwise hold.
- ARMED, enable=1, tick_in=0:
  - If counter is below all-ones: counter<=counter+1.
  - If counter is all-ones: counter holds and overflow<=1.
- ARMED, enable=1, tick_in=1 (capture):
  - period<=counter, valid<=1, counter<=1, state stays ARMED.
  - period_min<=min(period_min, counter); period_max<=max(period_max, counter).
  - meas_count<=meas_count+1, saturating at all-ones.
  - If counter is all-ones at capture: overflow<=1 and period=all-ones.
- valid is 1 only in the cycle after a capture edge; otherwise 0.
- Latency: a tick at edge k shows as valid=1 and updated period/min/max/count after edge k.
- Period definition: number of enabled edges from one tick edge to the next.
  - Ticks at enabled edges t and t+M give period=M.
  - Continuous tick_in=1 gives period=1 every cycle with valid held high.
- Enable gaps: cycles with enable=0 are not counted. A stream paused mid-period still measures M enabled cycles.
- Width rules:
  - All compares are unsigned WIDTH-bit.
  - period_min stays all-ones until the first capture.
  - No arithmetic wrap anywhere; counter and meas_count saturate.
- reset asserted mid-measurement: the partial count is discarded, and the next tick only re-arms.

Test Plan:
- Reset, enable=1, tick_in pulses at edges 10, 15, 20, 25 (period 5) -> IDLE until edge 10; valid after edges 15/20/25; period=5, min=5, max=5, meas_count=3, overflow=0.
- tick_in held 1 for 6 enabled edges -> first edge arms; valid high for the next 5 cycles; period=1, meas_count=5.
- Tick gaps of 3, 7, 4 cycles -> period sequence 3, 7, 4; period_min=3, period_max=7, meas_count=3.
- Period-4 stream with enable low for 2 cycles inside one period -> that period still reads 4, and the tick arriving while enable=0 is ignored (no valid).
- WIDTH=4 build, ticks 20 cycles apart -> counter saturates at 15; capture gives period=15, overflow=1 (sticky after further period-3 captures, which read 3).
- Assert clear in the same cycle as a tick after 2 captures, then assert async reset mid-period -> all outputs return to reset values, no valid, next tick only re-arms.
